// File: rtl/popcount_pkg.sv
// Shared width helpers and FSM encoding for the serial ones/zeros counter.
package popcount_pkg;

    // Bits needed to hold any value 0..n inclusive.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // CNT_W for a WIDTH-bit word.
    function automatic int cnt_width(input int width);
        return count_width(width);
    endfunction

    // Result width of one LANES-input ones counter.
    function automatic int lane_width(input int lanes);
        return count_width(lanes);
    endfunction

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LANES = 4;
    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);
    localparam int DEF_LW    = lane_width(DEF_LANES);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = IDLE,
        ST_COUNT = COUNT
    } state_e;

endpackage

// File: rtl/popcount_lane.sv
// Combinational LANES-input ones counter; one chunk of the serial word per cycle.
module popcount_lane
    import popcount_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int LW    = lane_width(LANES)
) (
    input  logic [LANES-1:0] bits,
    output logic [LW-1:0]    ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < LANES; i++) begin
            ones = ones + LW'(bits[i]);
        end
    end

endmodule

// File: rtl/popcount_serial.sv
// Serial popcount: counts ones (or zeros) of a WIDTH-bit word LANES bits per clock.
// Handshake: start is taken only while busy is low; done pulses one cycle when count/majority are new.
module popcount_serial
    import popcount_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         count_zeros,
    output logic                         busy,
    output logic                         done,
    output logic [cnt_width(WIDTH)-1:0]  count,
    output logic                         majority
);

    localparam int CNT_W  = cnt_width(WIDTH);
    localparam int LW     = lane_width(LANES);
    localparam int BEATS  = WIDTH / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (WIDTH < 1 || LANES < 1 || LANES > WIDTH || (WIDTH % LANES) != 0) begin : g_bad_params
        $error("popcount_serial: illegal WIDTH/LANES combination");
    end

    logic [0:0]        state;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  acc;
    logic [BEAT_W-1:0] beat;
    logic [LW-1:0]     lane_ones;
    logic [CNT_W-1:0]  sum;
    logic              last_beat;

    popcount_lane #(
        .LANES (LANES),
        .LW    (LW)
    ) u_lane (
        .bits (shreg[LANES-1:0]),
        .ones (lane_ones)
    );

    assign sum       = acc + CNT_W'(lane_ones);
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign busy      = (state == COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            acc      <= '0;
            beat     <= '0;
            done     <= 1'b0;
            count    <= '0;
            majority <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Zero counting is ones counting on the inverted word.
                        shreg <= count_zeros ? ~data_in : data_in;
                        acc   <= '0;
                        beat  <= '0;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    acc   <= sum;
                    shreg <= shreg >> LANES;
                    beat  <= beat + BEAT_W'(1);
                    if (last_beat) begin
                        count    <= sum;
                        majority <= (sum > CNT_W'(WIDTH / 2));
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_serial.sv
// Bench for popcount_serial: default 16/4 instance plus 7/7 and 7/1 sweep instances.
module tb_popcount_serial;

    localparam int BEATS = 4;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [15:0] data_in;
    logic        count_zeros;
    logic        busy;
    logic        done;
    logic [4:0]  count;
    logic        majority;

    logic        start7;
    logic [6:0]  d7;
    logic        z7;
    logic        busy7a, done7a, maj7a;
    logic [2:0]  cnt7a;
    logic        busy7b, done7b, maj7b;
    logic [2:0]  cnt7b;

    int n_checks = 0;
    int n_errors = 0;

    // {majority, count} expected for each accepted word, in order.
    logic [5:0] exp_q[$];

    popcount_serial #(.WIDTH(16), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .count_zeros(count_zeros), .busy(busy), .done(done),
        .count(count), .majority(majority)
    );

    popcount_serial #(.WIDTH(7), .LANES(7)) dut7a (
        .clk(clk), .rst_n(rst_n), .start(start7), .data_in(d7),
        .count_zeros(z7), .busy(busy7a), .done(done7a),
        .count(cnt7a), .majority(maj7a)
    );

    popcount_serial #(.WIDTH(7), .LANES(1)) dut7b (
        .clk(clk), .rst_n(rst_n), .start(start7), .data_in(d7),
        .count_zeros(z7), .busy(busy7b), .done(done7b),
        .count(cnt7b), .majority(maj7b)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: count bits of the low w bits of d that differ from cz.
    function automatic int ref_count(input logic [31:0] d, input int w, input logic cz);
        int n;
        n = 0;
        for (int i = 0; i < w; i++) if (d[i] != cz) n++;
        return n;
    endfunction

    // Scoreboard for the 16-bit instance
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("count", {27'd0, count}, {27'd0, e[4:0]});
                check("majority", {31'd0, majority}, {31'd0, e[5]});
            end
        end
    end

    function automatic logic [5:0] expect16(input logic [15:0] d, input logic cz);
        logic [4:0] c;
        c = 5'(ref_count({16'd0, d}, 16, cz));
        return {(c > 5'd8), c};
    endfunction

    // Driver: one word from idle; poke > 0 re-asserts start with FFFF at that beat.
    task automatic run_op(input logic [15:0] d, input logic cz, input int poke);
        logic [5:0] e;
        e = expect16(d, cz);
        exp_q.push_back(e);
        start = 1'b1; data_in = d; count_zeros = cz;
        @(posedge clk); #1;
        check("busy_e0", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= BEATS; k++) begin
            start       = (k == poke);
            data_in     = (k == poke) ? 16'hFFFF : 16'($urandom);
            count_zeros = 1'($urandom);
            @(posedge clk); #1;
            check("busy", {31'd0, busy}, {31'd0, k < BEATS});
            check("done", {31'd0, done}, {31'd0, k == BEATS});
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("done_clear", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("count_hold", {27'd0, count}, {27'd0, e[4:0]});
    endtask

    // Exhaustive 7-bit sweep on both degenerate-lane instances.
    task automatic sweep7();
        for (int v = 0; v < 128; v++) begin
            int   c;
            logic z;
            z = 1'($urandom);
            c = ref_count(32'(v), 7, z);
            start7 = 1'b1; d7 = 7'(v); z7 = z;
            @(posedge clk); #1;
            start7 = 1'b0; d7 = 7'($urandom); z7 = 1'($urandom);
            for (int k = 1; k <= 7; k++) begin
                @(posedge clk); #1;
                check("w7l7_done", {31'd0, done7a}, {31'd0, k == 1});
                check("w7l1_done", {31'd0, done7b}, {31'd0, k == 7});
                if (k == 1) begin
                    check("w7l7_count", {29'd0, cnt7a}, 32'(c));
                    check("w7l7_maj", {31'd0, maj7a}, {31'd0, c > 3});
                end
                if (k == 7) begin
                    check("w7l1_count", {29'd0, cnt7b}, 32'(c));
                    check("w7l1_maj", {31'd0, maj7b}, {31'd0, c > 3});
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; data_in = '0; count_zeros = 1'b0;
        start7 = 1'b0; d7 = '0; z7 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_majority", {31'd0, majority}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All ones, all zeros-count, strict majority boundary
        run_op(16'hFFFF, 1'b0, 0);
        run_op(16'h8001, 1'b1, 0);
        run_op(16'h00FF, 1'b0, 0);

        // start during busy is ignored
        run_op(16'h0000, 1'b0, 2);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_second_done", {31'd0, done}, 32'd0);
        end

        // start held high: accepts at E0 and E5
        exp_q.push_back(expect16(16'h0F0F, 1'b0));
        exp_q.push_back(expect16(16'h0001, 1'b0));
        start = 1'b1; data_in = 16'h0F0F; count_zeros = 1'b0;
        @(posedge clk); #1;
        data_in = 16'h0001;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check("held_busy", {31'd0, busy}, {31'd0, k != 4 && k != 9});
            check("held_done", {31'd0, done}, {31'd0, k == 4 || k == 9});
            if (k == 5) start = 1'b0;
        end
        @(posedge clk); #1;

        // Reset mid-operation aborts without done
        start = 1'b1; data_in = 16'hFFFF; count_zeros = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_count", {27'd0, count}, 32'd0);
        check("abort_majority", {31'd0, majority}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_op(16'hA5A5, 1'b0, 0);

        // Random words with random zero/one mode and random ignored restarts
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
        end

        sweep7();

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
